// File: rtl/cordic_angle_sequencer_pkg.sv
// Shared definitions for the CORDIC sin/cos angle sequencer.
// Contents: angle/data widths, angle constants, FSM state type, the payload
// structs, and a saturating 16-bit negation helper.
package cordic_angle_sequencer_pkg;

    localparam int unsigned ANGLE_W = 32;
    localparam int unsigned DATA_W  = 16;

    localparam logic [ANGLE_W-1:0] ANGLE_90      = 32'h4000_0000;
    localparam logic [ANGLE_W-1:0] ANGLE_M90     = 32'hC000_0000;
    localparam logic [ANGLE_W-1:0] ANGLE_180_MSB = 32'h8000_0000;

    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Folded angle handed to the core plus the half-turn flag.
    typedef struct packed {
        logic [ANGLE_W-1:0] angle;
        logic               flip;
    } fold_t;

    // Corrected sin/cos pair.
    typedef struct packed {
        logic [DATA_W-1:0] sin_val;
        logic [DATA_W-1:0] cos_val;
    } result_t;

    // Two's complement negation; the most negative code maps to the most positive.
    function automatic logic [DATA_W-1:0] sat_neg16(input logic [DATA_W-1:0] x);
        if (x == DATA_MIN) begin
            return DATA_MAX;
        end
        return DATA_W'(~x + DATA_W'(1));
    endfunction

endpackage

// File: rtl/cordic_angle_sequencer_if.sv
// Bundle of the request, result and core-side signals of the angle sequencer.
//  request : in_valid / in_ready / in_angle
//  result  : out_valid / out_ready / out_sin / out_cos / err
//  core    : core_start / core_angle / core_done / core_sin / core_cos
// slave  = the sequencer itself, master = its environment.
interface cordic_angle_sequencer_if;
    import cordic_angle_sequencer_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ANGLE_W-1:0] in_angle;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_sin;
    logic [DATA_W-1:0]  out_cos;
    logic               err;
    logic               core_start;
    logic [ANGLE_W-1:0] core_angle;
    logic               core_done;
    logic [DATA_W-1:0]  core_sin;
    logic [DATA_W-1:0]  core_cos;

    modport slave (
        input  in_valid, in_angle, out_ready, core_done, core_sin, core_cos,
        output in_ready, out_valid, out_sin, out_cos, err, core_start, core_angle
    );

    modport master (
        output in_valid, in_angle, out_ready, core_done, core_sin, core_cos,
        input  in_ready, out_valid, out_sin, out_cos, err, core_start, core_angle
    );

endinterface

// File: rtl/cordic_angle_sequencer_fold.sv
// Quadrant fold: maps a full-circle binary angle into the core's convergent
// range |theta| <= 90 deg by a half-turn when needed (combinational).
//  in_angle : signed binary angle, 2^32 = 360 deg
//  fold_c   : {folded angle, flip}; flip=1 when a half-turn was applied
module cordic_angle_sequencer_fold
    import cordic_angle_sequencer_pkg::*;
(
    input  logic [ANGLE_W-1:0] in_angle,
    output fold_t              fold_c
);

    // +/-90 deg stay put; -180 deg folds to 0 with flip set.
    always_comb begin
        fold_c.flip  = ($signed(in_angle) > $signed(ANGLE_90)) ||
                       ($signed(in_angle) < $signed(ANGLE_M90));
        fold_c.angle = fold_c.flip ? (in_angle ^ ANGLE_180_MSB) : in_angle;
    end

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Front end and result stage for the 16-iteration sin/cos rotation core.
// Accepts an angle, folds it, starts the core, waits for done (with timeout),
// restores quadrant/sign and presents sin/cos over a valid/ready handshake.
//  clk   : rising-edge clock
//  reset : asynchronous, active-high
//  bus   : request/result/core signals (slave side)
module cordic_angle_sequencer
    import cordic_angle_sequencer_pkg::*;
#(
    parameter bit          CORE_SIN_INV   = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    cordic_angle_sequencer_if.slave   bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               flip_q, flip_d;
    logic [ANGLE_W-1:0] core_angle_q, core_angle_d;
    logic               core_start_q, core_start_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    result_t            result_q, result_d;
    result_t            fix_c;
    fold_t              fold_c;

    cordic_angle_sequencer_fold u_fold (
        .in_angle (bus.in_angle),
        .fold_c   (fold_c)
    );

    // Undo the core's sin sense, then the half-turn fold.
    always_comb begin
        fix_c.sin_val = CORE_SIN_INV ? sat_neg16(bus.core_sin) : bus.core_sin;
        fix_c.cos_val = bus.core_cos;
        if (flip_q) begin
            fix_c.sin_val = sat_neg16(fix_c.sin_val);
            fix_c.cos_val = sat_neg16(fix_c.cos_val);
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        flip_d       = flip_q;
        core_angle_d = core_angle_q;
        out_valid_d  = out_valid_q;
        err_d        = err_q;
        result_d     = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    core_angle_d = fold_c.angle;
                    flip_d       = fold_c.flip;
                    err_d        = 1'b0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // timer_q==0 is the first WAIT cycle: a stale done may still show.
                if ((timer_q != '0) && bus.core_done) begin
                    result_d    = fix_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d    = '0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d   = (state_d == ST_IDLE);
        core_start_d = (state_d == ST_START);
    end

    // State and output registers; reset holds the core in its init state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            flip_q       <= 1'b0;
            core_angle_q <= '0;
            core_start_q <= 1'b1;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            flip_q       <= flip_d;
            core_angle_q <= core_angle_d;
            core_start_q <= core_start_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            result_q     <= result_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sin    = result_q.sin_val;
    assign bus.out_cos    = result_q.cos_val;
    assign bus.err        = err_q;
    assign bus.core_start = core_start_q;
    assign bus.core_angle = core_angle_q;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Self-checking bench for cordic_angle_sequencer: behavioural core model,
// reference sin/cos computed directly from the unfolded request angle,
// a per-cycle compare process and directed vectors with literal expectations.
module tb_cordic_angle_sequencer;
    import cordic_angle_sequencer_pkg::*;

    localparam int unsigned TO = 32;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;

    cordic_angle_sequencer_if bus();

    cordic_angle_sequencer #(
        .CORE_SIN_INV   (1'b1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        total++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic real to_rad(input logic [31:0] a);
        return $itor($signed(a)) * 2.0 * PI / 4294967296.0;
    endfunction

    function automatic int ref_sin(input logic [31:0] a);
        return rnd(16384.0 * $sin(to_rad(a)));
    endfunction

    function automatic int ref_cos(input logic [31:0] a);
        return rnd(16384.0 * $cos(to_rad(a)));
    endfunction

    // ---------------- behavioural core ----------------
    // mode 0: exact Q2.14 results with sin negated; 1: never done; 2: raw 0x8000 pair
    int          core_mode = 0;
    int unsigned core_cnt  = 0;
    logic        core_done_r = 1'b0;
    logic        stale = 1'b0;
    logic [15:0] core_sin_r = '0;
    logic [15:0] core_cos_r = '0;

    always @(posedge clk) begin
        if (bus.core_start) begin
            core_cnt    <= 0;
            core_done_r <= 1'b0;
            stale       <= core_done_r;
        end else begin
            stale <= 1'b0;
            if (!core_done_r && core_mode != 1) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 15) begin
                    core_done_r <= 1'b1;
                    if (core_mode == 2) begin
                        core_sin_r <= 16'h8000;
                        core_cos_r <= 16'h8000;
                    end else begin
                        core_sin_r <= 16'(-ref_sin(bus.core_angle));
                        core_cos_r <= 16'(ref_cos(bus.core_angle));
                    end
                end
            end
        end
    end

    assign bus.core_done = core_done_r | stale;
    assign bus.core_sin  = core_sin_r;
    assign bus.core_cos  = core_cos_r;

    // ---------------- per-cycle compare ----------------
    int   exp_s = 0, exp_c = 0, exp_tol = 0;
    int   exp_err = 0;
    logic p_valid = 1'b0;
    logic [15:0] p_s = '0, p_c = '0;
    logic p_err = 1'b0;

    initial begin
        logic rdy;
        forever begin
            @(posedge clk);
            rdy = bus.out_ready;
            #1;
            if (reset) begin
                p_valid = 1'b0;
            end else begin
                if (p_valid && !rdy) begin
                    check("hold_valid", int'(bus.out_valid), 1, 0);
                    check("hold_sin", $signed(bus.out_sin), $signed(p_s), 0);
                    check("hold_cos", $signed(bus.out_cos), $signed(p_c), 0);
                    check("hold_err", int'(bus.err), int'(p_err), 0);
                end
                if (bus.out_valid) begin
                    check("cmp_sin", $signed(bus.out_sin), exp_s, exp_tol);
                    check("cmp_cos", $signed(bus.out_cos), exp_c, exp_tol);
                    check("cmp_err", int'(bus.err), exp_err, 0);
                    check("cmp_ready_excl", int'(bus.in_ready), 0, 0);
                end
                p_valid = bus.out_valid;
                p_s     = bus.out_sin;
                p_c     = bus.out_cos;
                p_err   = bus.err;
            end
        end
    end

    // ---------------- directed request ----------------
    task automatic run_req(input logic [31:0] ang, input logic [31:0] exp_core,
                           input int lit_s, input int lit_c, input int mode,
                           input int hold, input string tag);
        int n;
        int lat;
        int tol;
        core_mode = mode;
        if (mode == 1) begin
            exp_s = 0; exp_c = 0; exp_tol = 0; exp_err = 1;
        end else if (mode == 2) begin
            exp_s = lit_s; exp_c = lit_c; exp_tol = 0; exp_err = 0;
        end else begin
            exp_s = ref_sin(ang); exp_c = ref_cos(ang); exp_tol = 4; exp_err = 0;
        end
        tol = (mode == 0) ? 4 : 0;

        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, int'(bus.in_ready), 1, 0);

        bus.in_valid = 1'b1;
        bus.in_angle = ang;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_angle = 32'hDEAD_BEEF;
        check({tag, "_core_start"}, int'(bus.core_start), 1, 0);
        check32({tag, "_core_angle"}, bus.core_angle, exp_core);
        check({tag, "_err_clr"}, int'(bus.err), 0, 0);

        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (mode == 1) ? int'(2 + TO) : 19, 0);
        check32({tag, "_core_angle_held"}, bus.core_angle, exp_core);
        check({tag, "_lit_sin"}, $signed(bus.out_sin), lit_s, tol);
        check({tag, "_lit_cos"}, $signed(bus.out_cos), lit_c, tol);

        repeat (hold) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.in_angle = 32'h1234_5678;
            check({tag, "_stall_ready"}, int'(bus.in_ready), 0, 0);
        end
        bus.in_valid = 1'b0;

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(bus.out_valid), 0, 0);
        check({tag, "_back_idle"}, int'(bus.in_ready), 1, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_angle = 32'h1555_5555;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0, 0);
        check("rst_out_valid", int'(bus.out_valid), 0, 0);
        check("rst_core_start", int'(bus.core_start), 1, 0);
        check32("rst_core_angle", bus.core_angle, 32'h0);
        check("rst_err", int'(bus.err), 0, 0);
        check("rst_out_sin", $signed(bus.out_sin), 0, 0);
        check("rst_out_cos", $signed(bus.out_cos), 0, 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(bus.in_ready), 1, 0);
        check("post_rst_start", int'(bus.core_start), 0, 0);

        run_req(32'h1555_5555, 32'h1555_5555,   8192,  14189, 0, 10, "deg30");
        run_req(32'h6AAA_AAAB, 32'hEAAA_AAAB,   8192, -14189, 0, 0,  "deg150");
        run_req(32'h4000_0000, 32'h4000_0000,  16384,      0, 0, 0,  "p90");
        run_req(32'hC000_0000, 32'hC000_0000, -16384,      0, 0, 0,  "m90");
        run_req(32'h8000_0000, 32'h0000_0000,      0, -16384, 0, 0,  "m180");
        run_req(32'h9555_5555, 32'h1555_5555,  -8192, -14189, 0, 0,  "m150");
        run_req(32'h1555_5555, 32'h1555_5555,      0,      0, 1, 3,  "timeout");
        run_req(32'h0000_0000, 32'h0000_0000,  32767, -32768, 2, 0,  "sat0");
        run_req(32'h8000_0000, 32'h0000_0000, -32767,  32767, 2, 0,  "satflip");

        // Abort in WAIT with an asynchronous reset.
        core_mode = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_angle = 32'h6AAA_AAAB;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("arst_out_valid", int'(bus.out_valid), 0, 0);
        check("arst_core_start", int'(bus.core_start), 1, 0);
        check("arst_in_ready", int'(bus.in_ready), 0, 0);
        check32("arst_core_angle", bus.core_angle, 32'h0);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("arst_idle_ready", int'(bus.in_ready), 1, 0);
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus.out_valid || bus.core_start) seen++;
            end
            check("arst_no_stale", seen, 0, 0);
        end
        run_req(32'hEAAA_AAAB, 32'hEAAA_AAAB,  -8192,  14189, 0, 2, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
